// File: rtl/zwrite_queue_arb.sv
// zwrite_queue_arb
// Posts Zorro host writes into a circular FIFO and arbitrates the single SDRAM
// command port between scanline fetches (always first) and queued writes
// (drained only in gaps, never while a host read holds the SDRAM).
//
// Ports:
//   z_sample_clk, reset        clock, synchronous active-high reset
//   wr_strobe/addr/uds/lds/data host write bus cycle (level strobe)
//   wr_ready, free_count        FIFO not full, DEPTH - occupancy
//   overflow                    sticky: a write was dropped because the FIFO was full
//   host_read_hold              blocks issue of any new SDRAM command
//   fetch_start, fetch_line     start (or restart) a scanline fetch
//   fetching                    fetch in progress
//   buf_we/addr/data            line buffer write port
//   cmd_ready, data_out(_ready) SDRAM controller status / read return
//   cmd_*                       SDRAM controller command port (all registered)
module zwrite_queue_arb #(
    parameter int                DEPTH      = 32,
    parameter int                ADDR_W     = 24,
    parameter int                RAM_ADDR_W = 21,
    parameter logic [ADDR_W-1:0] WIN_MASK   = 'hFFFFE,
    parameter int                LINE_WORDS = 800,
    parameter int                LINE_SHIFT = 10,
    parameter int                CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  z_sample_clk,
    input  logic                  reset,
    input  logic                  wr_strobe,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic                  wr_uds,
    input  logic                  wr_lds,
    input  logic [15:0]           wr_data,
    output logic                  wr_ready,
    output logic [CNT_W-1:0]      free_count,
    output logic                  overflow,
    input  logic                  host_read_hold,
    input  logic                  fetch_start,
    input  logic [11:0]           fetch_line,
    output logic                  fetching,
    output logic                  buf_we,
    output logic [10:0]           buf_addr,
    output logic [31:0]           buf_data,
    input  logic                  cmd_ready,
    input  logic [31:0]           data_out,
    input  logic                  data_out_ready,
    output logic                  cmd_enable,
    output logic                  cmd_wr,
    output logic [3:0]            cmd_byte_enable,
    output logic [RAM_ADDR_W-1:0] cmd_address,
    output logic [31:0]           cmd_data_in
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int IDX_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int ENTRY_W = RAM_ADDR_W + 4 + 16;
    localparam int FA_W    = 12 + LINE_SHIFT + 2;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH_ISSUE, FETCH_WAIT} state_t;

    state_t state_reg, state_next;

    logic                  strobe_prev_reg;
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [CNT_W-1:0]      free_count_reg;
    logic                  wr_ready_reg, overflow_reg, fetching_reg;
    logic [11:0]           line_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [1:0]            stale_reg, stale_next;
    logic                  cmd_enable_reg, cmd_wr_reg;
    logic [3:0]            cmd_be_reg;
    logic [RAM_ADDR_W-1:0] cmd_address_reg;
    logic [31:0]           cmd_data_reg;
    logic                  buf_we_reg;
    logic [10:0]           buf_addr_reg;
    logic [31:0]           buf_data_reg;

    logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
    logic [ENTRY_W-1:0]    push_entry, head_entry;
    logic [3:0]            push_be;

    logic capture, has_bytes, full, empty, push, pop;
    logic can_issue, issue_wr, issue_rd, accept, consume_stale, abort_wait;

    // ---------------------------------------------------------------
    // Capture: one entry per rising edge of the level strobe
    // ---------------------------------------------------------------
    assign capture   = wr_strobe && !strobe_prev_reg;
    assign has_bytes = wr_uds || wr_lds;
    assign full      = (count_reg == DEPTH_CNT);
    assign empty     = (count_reg == '0);
    assign push      = capture && has_bytes && !full;
    assign pop       = issue_wr;

    // Odd lanes follow UDS, even lanes LDS: gives 1010 / 0101 / 1111.
    for (genvar gi = 0; gi < 4; gi++) begin : g_be
        assign push_be[gi] = (gi % 2 == 1) ? wr_uds : wr_lds;
    end

    // Address is mapped into SDRAM space once, at capture time.
    assign push_entry = {RAM_ADDR_W'({wr_addr & WIN_MASK, 1'b0}), push_be, wr_data};

    // The head entry feeds the registered command outputs directly, so the
    // queue is read asynchronously and the command registers act as the
    // read register.
    assign head_entry = fifo_mem[rd_ptr_reg];

    always_ff @(posedge z_sample_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // ---------------------------------------------------------------
    // Read-return bookkeeping. stale_reg counts reads issued for an
    // aborted line whose data has not come back yet; returns are in order,
    // so the oldest returns are the stale ones and are discarded.
    // ---------------------------------------------------------------
    assign consume_stale = data_out_ready && (stale_reg != 2'd0);
    assign accept        = data_out_ready && (stale_reg == 2'd0) &&
                           (state_reg == FETCH_WAIT) && !fetch_start;
    // Abort while waiting leaves one read in flight, unless its data
    // returns in this very cycle (then it is simply dropped).
    assign abort_wait    = fetch_start && (state_reg == FETCH_WAIT) &&
                           !(data_out_ready && (stale_reg == 2'd0));

    always_comb begin
        stale_next = stale_reg;
        if (consume_stale && !abort_wait) begin
            stale_next = stale_reg - 2'd1;
        end else if (abort_wait && !consume_stale) begin
            stale_next = stale_reg + 2'd1;
        end
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge z_sample_clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (fetch_start) state_next = FETCH_ISSUE;
            end
            FETCH_ISSUE: begin
                if (fetch_start)   state_next = FETCH_ISSUE;
                else if (issue_rd) state_next = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (fetch_start)   state_next = FETCH_ISSUE;
                else if (accept)   state_next = (idx_reg == IDX_LAST) ? IDLE : FETCH_ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: output decisions. The !cmd_enable_reg term forces an idle cycle
    // after every issued command.
    assign can_issue = !host_read_hold && cmd_ready && !cmd_enable_reg;

    always_comb begin
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        case (state_reg)
            IDLE:        issue_wr = can_issue && !empty;
            FETCH_ISSUE: issue_rd = can_issue && !fetch_start;
            default:     ;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge z_sample_clk) begin
        if (reset) begin
            strobe_prev_reg <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            free_count_reg  <= DEPTH_CNT;
            wr_ready_reg    <= 1'b1;
            overflow_reg    <= 1'b0;
            fetching_reg    <= 1'b0;
            line_reg        <= '0;
            idx_reg         <= '0;
            stale_reg       <= '0;
            cmd_enable_reg  <= 1'b0;
            cmd_wr_reg      <= 1'b0;
            cmd_be_reg      <= 4'b0000;
            cmd_address_reg <= '0;
            cmd_data_reg    <= '0;
            buf_we_reg      <= 1'b0;
            buf_addr_reg    <= '0;
            buf_data_reg    <= '0;
        end else begin
            strobe_prev_reg <= wr_strobe;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg      <= count_next;
            free_count_reg <= DEPTH_CNT - count_next;
            wr_ready_reg   <= (count_next != DEPTH_CNT);
            if (capture && has_bytes && full) overflow_reg <= 1'b1;

            fetching_reg <= (state_next != IDLE);
            if (fetch_start) begin
                line_reg <= fetch_line;
                idx_reg  <= '0;
            end else if (accept) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
            stale_reg <= stale_next;

            cmd_enable_reg <= issue_wr || issue_rd;
            cmd_wr_reg     <= issue_wr;
            if (issue_wr) begin
                cmd_address_reg <= head_entry[ENTRY_W-1 -: RAM_ADDR_W];
                cmd_be_reg      <= head_entry[19:16];
                cmd_data_reg    <= {head_entry[15:0], head_entry[15:0]};
            end else if (issue_rd) begin
                cmd_be_reg      <= 4'b1111;
                cmd_address_reg <= RAM_ADDR_W'((FA_W'(line_reg) << (LINE_SHIFT + 2)) |
                                               (FA_W'(idx_reg) << 2));
            end

            buf_we_reg <= accept;
            if (accept) begin
                buf_addr_reg <= 11'(idx_reg);
                buf_data_reg <= data_out;
            end
        end
    end

    assign wr_ready        = wr_ready_reg;
    assign free_count      = free_count_reg;
    assign overflow        = overflow_reg;
    assign fetching        = fetching_reg;
    assign buf_we          = buf_we_reg;
    assign buf_addr        = buf_addr_reg;
    assign buf_data        = buf_data_reg;
    assign cmd_enable      = cmd_enable_reg;
    assign cmd_wr          = cmd_wr_reg;
    assign cmd_byte_enable = cmd_be_reg;
    assign cmd_address     = cmd_address_reg;
    assign cmd_data_in     = cmd_data_reg;
endmodule

// File: tb/tb_zwrite_queue_arb.sv
// tb_zwrite_queue_arb
// Directed bench for zwrite_queue_arb (DEPTH=32, LINE_WORDS=4, LINE_SHIFT=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A small SDRAM responder returns read data (D000_0000 ^ address) after a
// programmable delay; a monitor logs every command and line buffer write.
module tb_zwrite_queue_arb;
    logic        clk;
    logic        reset;
    logic        wr_strobe;
    logic [23:0] wr_addr;
    logic        wr_uds, wr_lds;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [5:0]  free_count;
    logic        overflow;
    logic        host_read_hold;
    logic        fetch_start;
    logic [11:0] fetch_line;
    logic        fetching;
    logic        buf_we;
    logic [10:0] buf_addr;
    logic [31:0] buf_data;
    logic        cmd_ready;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        cmd_enable, cmd_wr;
    logic [3:0]  cmd_byte_enable;
    logic [20:0] cmd_address;
    logic [31:0] cmd_data_in;

    int assert_count = 0;
    int fail_count   = 0;
    int resp_delay   = 1;

    logic [20:0] cmd_addr_q[$];
    logic        cmd_wr_q[$];
    logic [3:0]  cmd_be_q[$];
    logic [31:0] cmd_data_q[$];
    logic [10:0] buf_addr_q[$];
    logic [31:0] buf_data_q[$];
    int          rsp_cnt_q[$];
    logic [31:0] rsp_data_q[$];
    logic        prev_en;

    zwrite_queue_arb #(
        .DEPTH(32), .ADDR_W(24), .RAM_ADDR_W(21), .WIN_MASK(24'hFFFFE),
        .LINE_WORDS(4), .LINE_SHIFT(8)
    ) dut (
        .z_sample_clk(clk), .reset(reset),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_uds(wr_uds), .wr_lds(wr_lds),
        .wr_data(wr_data), .wr_ready(wr_ready), .free_count(free_count),
        .overflow(overflow), .host_read_hold(host_read_hold),
        .fetch_start(fetch_start), .fetch_line(fetch_line), .fetching(fetching),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
        .cmd_ready(cmd_ready), .data_out(data_out), .data_out_ready(data_out_ready),
        .cmd_enable(cmd_enable), .cmd_wr(cmd_wr), .cmd_byte_enable(cmd_byte_enable),
        .cmd_address(cmd_address), .cmd_data_in(cmd_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Command / buffer monitor, one line per transaction.
    always @(negedge clk) begin
        if (reset) begin
            prev_en = 1'b0;
        end else begin
            if (cmd_enable) begin
                check_eq("cmd_gap_prev_enable", {63'd0, prev_en}, 64'd0);
                cmd_addr_q.push_back(cmd_address);
                cmd_wr_q.push_back(cmd_wr);
                cmd_be_q.push_back(cmd_byte_enable);
                cmd_data_q.push_back(cmd_data_in);
                $display("%0t cmd wr=%0d be=%b addr=%h data=%h", $time, cmd_wr,
                         cmd_byte_enable, cmd_address, cmd_data_in);
            end
            if (buf_we) begin
                buf_addr_q.push_back(buf_addr);
                buf_data_q.push_back(buf_data);
                $display("%0t buf addr=%0d data=%h", $time, buf_addr, buf_data);
            end
            prev_en = cmd_enable;
        end
    end

    // SDRAM read responder (in-order returns).
    always @(negedge clk) begin
        data_out_ready = 1'b0;
        if (reset) begin
            rsp_cnt_q.delete();
            rsp_data_q.delete();
        end else begin
            if (rsp_cnt_q.size() > 0 && rsp_cnt_q[0] <= 0) begin
                data_out_ready = 1'b1;
                data_out       = rsp_data_q[0];
                void'(rsp_cnt_q.pop_front());
                void'(rsp_data_q.pop_front());
            end
            for (int i = 0; i < rsp_cnt_q.size(); i++) rsp_cnt_q[i] = rsp_cnt_q[i] - 1;
            if (cmd_enable && !cmd_wr) begin
                rsp_cnt_q.push_back(resp_delay);
                rsp_data_q.push_back(32'hD000_0000 ^ {11'd0, cmd_address});
            end
        end
    end

    task automatic clear_logs();
        cmd_addr_q.delete(); cmd_wr_q.delete(); cmd_be_q.delete(); cmd_data_q.delete();
        buf_addr_q.delete(); buf_data_q.delete();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Strobe is held for two cycles so a second capture would show up.
    task automatic host_write(input logic [23:0] a, input logic u, input logic l,
                              input logic [15:0] d);
        wr_addr = a; wr_uds = u; wr_lds = l; wr_data = d; wr_strobe = 1'b1;
        cycles(2);
        wr_strobe = 1'b0;
        cycles(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] ea;
        logic [3:0]  eb;
        logic [15:0] ed;
        logic        seen;

        wr_strobe = 0; wr_addr = 0; wr_uds = 0; wr_lds = 0; wr_data = 0;
        host_read_hold = 0; fetch_start = 0; fetch_line = 0;
        cmd_ready = 0; data_out = 0; data_out_ready = 0;
        @(negedge clk);
        do_reset();

        // ---- reset state ----
        check_eq("rst_free_count", free_count, 32);
        check_eq("rst_wr_ready", wr_ready, 1);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_cmd_enable", cmd_enable, 0);
        check_eq("rst_fetching", fetching, 0);
        check_eq("rst_byte_enable", cmd_byte_enable, 0);
        check_eq("rst_cmd_address", cmd_address, 0);

        // ---- single write with cycle-accurate latency ----
        cmd_ready = 1;
        clear_logs();
        wr_addr = 24'h200010; wr_uds = 1; wr_lds = 0; wr_data = 16'hABCD; wr_strobe = 1;
        @(negedge clk);
        check_eq("single_t1_free_count", free_count, 31);
        check_eq("single_t1_cmd_enable", cmd_enable, 0);
        @(negedge clk);
        check_eq("single_t2_cmd_enable", cmd_enable, 1);
        check_eq("single_cmd_wr", cmd_wr, 1);
        check_eq("single_byte_enable", cmd_byte_enable, 4'b1010);
        check_eq("single_cmd_address", cmd_address, 21'h20);
        check_eq("single_cmd_data", cmd_data_in, 32'hABCDABCD);
        check_eq("single_free_count_after_pop", free_count, 32);
        wr_strobe = 0;
        @(negedge clk);
        check_eq("single_pulse_low", cmd_enable, 0);
        cycles(4);
        check_eq("single_cmd_count", cmd_addr_q.size(), 1);

        // ---- write with no byte strobes is ignored ----
        clear_logs();
        host_write(24'h000100, 0, 0, 16'h1111);
        cycles(4);
        check_eq("nobytes_free_count", free_count, 32);
        check_eq("nobytes_cmd_count", cmd_addr_q.size(), 0);
        check_eq("nobytes_overflow", overflow, 0);

        // ---- fill, overflow, drain across pointer wrap ----
        cmd_ready = 0;
        clear_logs();
        for (int i = 0; i < 33; i++)
            host_write(24'h3F0000 + 24'(i * 6), (i % 3) != 2, (i % 3) != 1, 16'h5A00 + 16'(i));
        check_eq("fill_free_count", free_count, 0);
        check_eq("fill_wr_ready", wr_ready, 0);
        check_eq("fill_overflow", overflow, 1);
        cmd_ready = 1;
        cycles(120);
        check_eq("drain_cmd_count", cmd_addr_q.size(), 32);
        for (int i = 0; i < 32 && i < cmd_addr_q.size(); i++) begin
            ea = 21'h1E0000 + 21'(i * 12);
            eb = (i % 3 == 0) ? 4'hF : ((i % 3 == 1) ? 4'hA : 4'h5);
            ed = 16'h5A00 + 16'(i);
            check_eq($sformatf("drain_addr_%0d", i), cmd_addr_q[i], ea);
            check_eq($sformatf("drain_be_%0d", i), cmd_be_q[i], eb);
            check_eq($sformatf("drain_data_%0d", i), cmd_data_q[i], {ed, ed});
        end
        check_eq("drain_free_count", free_count, 32);
        check_eq("drain_wr_ready", wr_ready, 1);
        check_eq("overflow_sticky", overflow, 1);

        do_reset();
        check_eq("reset_clears_overflow", overflow, 0);

        // ---- fetch priority over queued writes ----
        cmd_ready = 0;
        resp_delay = 1;
        clear_logs();
        for (int i = 0; i < 4; i++)
            host_write(24'h000400 + 24'(i * 2), 1, 1, 16'hC000 + 16'(i));
        fetch_line = 12'd5; fetch_start = 1;
        @(negedge clk);
        fetch_start = 0;
        check_eq("fetch_fetching_high", fetching, 1);
        cmd_ready = 1;
        cycles(60);
        check_eq("fetch_cmd_count", cmd_addr_q.size(), 8);
        for (int k = 0; k < 8 && k < cmd_addr_q.size(); k++) begin
            if (k < 4) begin
                check_eq($sformatf("fetch_rd_addr_%0d", k), cmd_addr_q[k], 21'h1400 + 21'(4 * k));
                check_eq($sformatf("fetch_rd_wr_%0d", k), cmd_wr_q[k], 0);
                check_eq($sformatf("fetch_rd_be_%0d", k), cmd_be_q[k], 4'hF);
            end else begin
                check_eq($sformatf("fetch_wr_wr_%0d", k), cmd_wr_q[k], 1);
                check_eq($sformatf("fetch_wr_addr_%0d", k), cmd_addr_q[k], 21'h800 + 21'(4 * (k - 4)));
                ed = 16'hC000 + 16'(k - 4);
                check_eq($sformatf("fetch_wr_data_%0d", k), cmd_data_q[k], {ed, ed});
            end
        end
        check_eq("fetch_buf_count", buf_addr_q.size(), 4);
        for (int k = 0; k < 4 && k < buf_addr_q.size(); k++) begin
            check_eq($sformatf("fetch_buf_addr_%0d", k), buf_addr_q[k], 11'(k));
            check_eq($sformatf("fetch_buf_data_%0d", k), buf_data_q[k], 32'hD000_1400 + 32'(4 * k));
        end
        check_eq("fetch_fetching_low", fetching, 0);

        // ---- host_read_hold blocks the drain ----
        clear_logs();
        host_read_hold = 1;
        host_write(24'h000010, 1, 0, 16'h1234);
        host_write(24'h000012, 0, 1, 16'h5678);
        cycles(5);
        check_eq("hold_cmd_count", cmd_addr_q.size(), 0);
        check_eq("hold_free_count", free_count, 30);
        host_read_hold = 0;
        @(negedge clk);
        check_eq("hold_release_enable", cmd_enable, 1);
        check_eq("hold_release_addr", cmd_address, 21'h20);
        cycles(8);
        check_eq("hold_drain_count", cmd_addr_q.size(), 2);
        check_eq("hold_free_count_after", free_count, 32);

        // ---- fetch restart discards in-flight read ----
        clear_logs();
        resp_delay = 4;
        fetch_line = 12'd5; fetch_start = 1;
        @(negedge clk);
        fetch_start = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cmd_enable) seen = 1;
        end
        check_eq("restart_first_read_seen", seen, 1);
        fetch_line = 12'd2; fetch_start = 1;
        @(negedge clk);
        fetch_start = 0;
        cycles(60);
        check_eq("restart_cmd_count", cmd_addr_q.size(), 5);
        if (cmd_addr_q.size() > 0) check_eq("restart_stale_addr", cmd_addr_q[0], 21'h1400);
        for (int k = 1; k < 5 && k < cmd_addr_q.size(); k++)
            check_eq($sformatf("restart_rd_addr_%0d", k), cmd_addr_q[k], 21'h800 + 21'(4 * (k - 1)));
        check_eq("restart_buf_count", buf_addr_q.size(), 4);
        for (int k = 0; k < 4 && k < buf_addr_q.size(); k++) begin
            check_eq($sformatf("restart_buf_addr_%0d", k), buf_addr_q[k], 11'(k));
            check_eq($sformatf("restart_buf_data_%0d", k), buf_data_q[k], 32'hD000_0800 + 32'(4 * k));
        end
        check_eq("restart_fetching_low", fetching, 0);

        // ---- reset mid-drain discards queued writes ----
        resp_delay = 1;
        cmd_ready = 0;
        for (int i = 0; i < 3; i++) host_write(24'h000020 + 24'(i * 2), 1, 1, 16'h7700 + 16'(i));
        check_eq("middrain_free_count", free_count, 29);
        clear_logs();
        cmd_ready = 1;
        do_reset();
        cycles(10);
        check_eq("middrain_cmd_count", cmd_addr_q.size(), 0);
        check_eq("middrain_free_count_after", free_count, 32);
        check_eq("middrain_wr_ready", wr_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
